// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, word width and PC stepping constants.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;

    // Instruction encoding that stops fetch (unprogrammed-ROM filler).
    localparam logic [WORD_W-1:0] HALT_WORD = 16'hF800;

    // Byte distance between consecutive 16-bit instructions.
    localparam logic [WORD_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its pc+2 link value and a valid flag.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              hold,
    input  logic              clear,
    input  logic [WORD_W-1:0] fetch_instr,
    input  logic [WORD_W-1:0] fetch_pc_plus2,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_plus2,
    output logic              valid
);

    // Priority clear > hold > load; with no control asserted the contents stay
    // but valid drops, which is how a halted front end presents bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            instr    <= '0;
            valid    <= 1'b0;
        end else if (hold) begin
            instr    <= instr;
        end else if (load) begin
            instr    <= fetch_instr;
            pc_plus2 <= fetch_pc_plus2;
            valid    <= 1'b1;
        end else begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RUN/HALT control and delivered-instruction counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [15:0] instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] pc_plus2;
    logic              reg_load;
    logic              reg_hold;
    logic              reg_clear;
    logic              count_inc;

    assign pc_plus2 = pc + PC_STEP;
    assign halted   = (state == HALT);

    // Next-state and IF/ID control, priority redirect > stall > halt detect > advance.
    // HALT is tested before stall because a halted front end ignores stall.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        reg_load   = 1'b0;
        reg_hold   = 1'b0;
        reg_clear  = 1'b0;
        count_inc  = 1'b0;
        if (redirect) begin
            next_pc    = redirect_pc & 16'hFFFE;
            reg_clear  = 1'b1;
            next_state = RUN;
        end else if (state == HALT) begin
            next_state = HALT;
        end else if (stall) begin
            reg_hold   = 1'b1;
        end else if (instruction == HALT_WORD) begin
            reg_load   = 1'b1;
            count_inc  = 1'b1;
            next_state = HALT;
        end else begin
            reg_load   = 1'b1;
            count_inc  = 1'b1;
            next_pc    = pc_plus2;
        end
    end

    // PC, FSM state and saturating fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (count_inc && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (reg_load),
        .hold           (reg_hold),
        .clear          (reg_clear),
        .fetch_instr    (instruction),
        .fetch_pc_plus2 (pc_plus2),
        .instr          (if_id_instr),
        .pc_plus2       (if_id_pc_plus2),
        .valid          (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a small ROM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] rom [0:127];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [17];

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .HALT_WORD (16'hF800)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instruction    (instruction),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory of 256 bytes; anything at or above 256 reads as zero.
    assign instruction = (pc < 16'd256) ? rom[pc[7:1]] : 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " pc"},     pc,                   v.pc);
        chk({tag, " instr"},  if_id_instr,          v.instr);
        chk({tag, " pp2"},    if_id_pc_plus2,       v.pp2);
        chk({tag, " valid"},  {15'd0, if_id_valid}, {15'd0, v.valid});
        chk({tag, " halted"}, {15'd0, halted},      {15'd0, v.halted});
        chk({tag, " count"},  fetch_count,          v.cnt);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h1111;
        rom[1]  = 16'h2222;
        rom[2]  = 16'h3333;
        rom[3]  = 16'h4444;
        rom[4]  = 16'h5555;
        rom[8]  = 16'h9999;
        rom[9]  = 16'hAAAA;
        rom[10] = 16'hF800;

        //             stall redir rpc       pc        instr     pp2       v     h     cnt
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0004, 16'h2222, 16'h0004, 1'b1, 1'b0, 16'd2};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h2222, 16'h0004, 1'b1, 1'b0, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h2222, 16'h0004, 1'b1, 1'b0, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0006, 16'h3333, 16'h0006, 1'b1, 1'b0, 16'd3};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0008, 16'h4444, 16'h0008, 1'b1, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 1'b1, 16'h0011, 16'h0010, 16'h0000, 16'h0008, 1'b0, 1'b0, 16'd4};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0012, 16'h9999, 16'h0012, 1'b1, 1'b0, 16'd5};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0014, 16'hAAAA, 16'h0014, 1'b1, 1'b0, 16'd6};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0014, 16'hF800, 16'h0016, 1'b1, 1'b1, 16'd7};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0014, 16'hF800, 16'h0016, 1'b0, 1'b1, 16'd7};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0014, 16'hF800, 16'h0016, 1'b0, 1'b1, 16'd7};
        vecs[12] = '{1'b0, 1'b1, 16'h0008, 16'h0008, 16'h0000, 16'h0016, 1'b0, 1'b0, 16'd7};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h000A, 16'h5555, 16'h000A, 1'b1, 1'b0, 16'd8};
        vecs[14] = '{1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h000A, 1'b0, 1'b0, 16'd8};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'd9};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0, 16'd10};

        rv = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0};

        // Reset values while rst_n is held low.
        #12;
        chk_all("reset", rv);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("post_release", rv);

        for (int i = 0; i < 17; i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end
        stall    = 1'b0;
        redirect = 1'b0;

        // Asynchronous reset between edges: outputs must clear before the next edge.
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", rv);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rv = '{1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0, 16'd1};
        chk_all("restart", rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

endmodule
